complex_mult_host: RTL
======================

// Module: complex_mult_host
// PURPOSE
//  Initiator for the complex multiplier's op_val/op_ready and res_val/res_ready handshakes.
//  - Buffers operand pairs written by an upstream source in a small FIFO.
//  - Issues one transaction at a time to the multiplier and collects its result.
//  - Presents the result on a valid/ready readout port and counts completed transactions.
// PARAMETERS
//  DATA_WIDTH      8   width of one real or imaginary operand component
//  FIFO_DEPTH      4   operand FIFO entries; power of 2, >= 2
//  TIMEOUT_CYCLES  64  WAIT_RES watchdog limit; used only with CMH_TIMEOUT_EN
// PORTS
//  clk        in   1             clock, rising edge
//  rst        in   1             asynchronous reset, active high
//  sw_rst     in   1             synchronous software reset, active high
//  in_wr      in   1             push in_data into the operand FIFO
//  in_data    in   4*DATA_WIDTH  {op1_re, op1_im, op2_re, op2_im}, MSB first
//  in_full    out  1             FIFO full
//  op_val     out  1             operand valid to multiplier
//  op_ready   in   1             multiplier accepts operands
//  op_data    out  4*DATA_WIDTH  operands to multiplier (same packing as in_data)
//  res_val    in   1             multiplier result valid
//  res_ready  out  1             host accepts result
//  res_data   in   4*DATA_WIDTH  {re, im}; each 2*DATA_WIDTH wide, two's complement
//  out_val    out  1             captured result valid
//  out_ready  in   1             downstream accepts captured result
//  out_re     out  2*DATA_WIDTH  captured real part
//  out_im     out  2*DATA_WIDTH  captured imaginary part
//  busy       out  1             state != IDLE or FIFO not empty
//  txn_cnt    out  16            completed readout handshakes, wraps 0xFFFF -> 0
// BEHAVIOUR
//  - Reset: rst (async) or sw_rst (sync, highest priority) clears FSM to IDLE and empties the FIFO.
//    All outputs reset to 0: in_full, op_val, op_data, res_ready, out_val, out_re, out_im, busy, txn_cnt.
//  - FIFO push: in_wr=1 and in_full=0 -> write at wr_ptr. in_wr while full -> write dropped, no state change.
//    Full is evaluated before a same-cycle pop, so a write in the pop cycle is still dropped if full.
//  - FIFO pop: only on the op_val & op_ready handshake. Pointers wrap modulo FIFO_DEPTH.
//    Extra pointer bit distinguishes full from empty.
//  - FSM IDLE: FIFO non-empty -> ISSUE next cycle; op_data registered from FIFO head on that edge.
//  - FSM ISSUE: op_val=1, op_data held stable. op_ready=1 -> pop FIFO, op_val=0 next cycle, go to WAIT_RES.
//  - FSM WAIT_RES: res_ready=1 (registered).
//    On res_val & res_ready: out_re <= res_data[4DW-1:2DW], out_im <= res_data[2DW-1:0],
//    res_ready=0 next cycle, go to DELIVER.
//    res_val outside WAIT_RES is ignored (res_ready=0).
//  - FSM DELIVER: out_val=1, out_re and out_im stable.
//    out_ready=1 -> out_val=0, txn_cnt+1, go to IDLE.
//  - Latency: FIFO write to op_val = 2 cycles when IDLE and empty.
//    Result capture to out_val = 1 cycle.
//  - Only one transaction in flight; a new issue waits for the readout handshake.
//  - sw_rst mid-transaction abandons it; the multiplier must be reset alongside.
// CONFIGURATION
//  CMH_TIMEOUT_EN defined:
//  - 16-bit watchdog counts cycles in WAIT_RES.
//  - Count reaches TIMEOUT_CYCLES with no res_val -> go to IDLE, res_ready=0.
//  - Sticky output port timeout_err (1 bit) is set; cleared only by rst or sw_rst.
//  - The abandoned entry is not retried; txn_cnt is unchanged.
//  CMH_TIMEOUT_EN undefined:
//  - No watchdog and no timeout_err port; WAIT_RES waits indefinitely.
// TESTING
//  1. in_data=0x03020104, model returns res_data=0xFFFB000E ->
//     op_data=0x03020104, out_re=0xFFFB, out_im=0x000E, txn_cnt=1.
//  2. Five back-to-back writes, FIFO_DEPTH=4, stalled multiplier -> in_full=1 after the 4th write (no pop yet).
//     5th write dropped; exactly 4 results delivered in write order.
//  3. op_ready held 0 for 10 cycles in ISSUE -> op_val stays 1, op_data unchanged, FIFO count unchanged.
//  4. out_ready held 0 for 5 cycles in DELIVER ->
//     out_val stays 1, out_re/out_im stable, no new op_val despite non-empty FIFO.
//  5. sw_rst in WAIT_RES with 2 entries queued -> next cycle all outputs 0, busy=0, in_full=0.
//     Later res_val is ignored.
//  6. CMH_TIMEOUT_EN, TIMEOUT_CYCLES=8, res_val never asserted -> timeout_err=1 after 8 WAIT_RES cycles.
//     FSM returns to IDLE; next queued entry is issued.

Source files
------------

// File: rtl/complex_mult_host.sv
// rtl/complex_mult_host.sv - operand FIFO and handshake initiator for the complex multiplier (optional watchdog: CMH_TIMEOUT_EN)
module complex_mult_host #(
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sw_rst,
    input  logic                      in_wr,
    input  logic [4*DATA_WIDTH-1:0]   in_data,
    output logic                      in_full,
    output logic                      op_val,
    input  logic                      op_ready,
    output logic [4*DATA_WIDTH-1:0]   op_data,
    input  logic                      res_val,
    output logic                      res_ready,
    input  logic [4*DATA_WIDTH-1:0]   res_data,
    output logic                      out_val,
    input  logic                      out_ready,
    output logic [2*DATA_WIDTH-1:0]   out_re,
    output logic [2*DATA_WIDTH-1:0]   out_im,
    output logic                      busy,
    output logic [15:0]               txn_cnt
`ifdef CMH_TIMEOUT_EN
    ,
    output logic                      timeout_err
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW4 = 4 * DATA_WIDTH;
    localparam int DW2 = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES, DELIVER} state_t;

    state_t           state_q, state_d;
    logic [DW4-1:0]   mem_q [FIFO_DEPTH];
    logic [DW4-1:0]   mem_d [FIFO_DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             op_val_q, op_val_d;
    logic [DW4-1:0]   op_data_q, op_data_d;
    logic             res_ready_q, res_ready_d;
    logic             out_val_q, out_val_d;
    logic [DW2-1:0]   out_re_q, out_re_d;
    logic [DW2-1:0]   out_im_q, out_im_d;
    logic [15:0]      txn_cnt_q, txn_cnt_d;
`ifdef CMH_TIMEOUT_EN
    logic [15:0]      wd_cnt_q, wd_cnt_d;
    logic             timeout_err_q, timeout_err_d;
`endif

    logic fifo_empty;
    logic fifo_full;

    // The extra pointer bit separates a full FIFO from an empty one
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // FIFO push/pop, transaction FSM and output registers; sw_rst overrides everything
    always_comb begin
        state_d     = state_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        op_val_d    = op_val_q;
        op_data_d   = op_data_q;
        res_ready_d = res_ready_q;
        out_val_d   = out_val_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        txn_cnt_d   = txn_cnt_q;
`ifdef CMH_TIMEOUT_EN
        wd_cnt_d      = wd_cnt_q;
        timeout_err_d = timeout_err_q;
`endif

        // Full is judged on the registered pointers, so a write in a pop cycle is still dropped
        if (in_wr && !fifo_full) begin
            mem_d[wr_ptr_q[AW-1:0]] = in_data;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d   = ISSUE;
                    op_val_d  = 1'b1;
                    op_data_d = mem_q[rd_ptr_q[AW-1:0]];
                end
            end
            ISSUE: begin
                if (op_ready) begin
                    rd_ptr_d    = rd_ptr_q + 1'b1;
                    op_val_d    = 1'b0;
                    res_ready_d = 1'b1;
                    state_d     = WAIT_RES;
`ifdef CMH_TIMEOUT_EN
                    wd_cnt_d    = 16'd0;
`endif
                end
            end
            WAIT_RES: begin
                if (res_val && res_ready_q) begin
                    out_re_d    = res_data[DW4-1:DW2];
                    out_im_d    = res_data[DW2-1:0];
                    res_ready_d = 1'b0;
                    out_val_d   = 1'b1;
                    state_d     = DELIVER;
                end
`ifdef CMH_TIMEOUT_EN
                else if (wd_cnt_q + 16'd1 == 16'(TIMEOUT_CYCLES)) begin
                    // Abandon the stuck entry; it is not retried
                    res_ready_d   = 1'b0;
                    timeout_err_d = 1'b1;
                    wd_cnt_d      = 16'd0;
                    state_d       = IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + 16'd1;
                end
`endif
            end
            DELIVER: begin
                if (out_ready) begin
                    out_val_d = 1'b0;
                    txn_cnt_d = txn_cnt_q + 16'd1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (sw_rst) begin
            state_d     = IDLE;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            op_val_d    = 1'b0;
            op_data_d   = '0;
            res_ready_d = 1'b0;
            out_val_d   = 1'b0;
            out_re_d    = '0;
            out_im_d    = '0;
            txn_cnt_d   = 16'd0;
`ifdef CMH_TIMEOUT_EN
            wd_cnt_d      = 16'd0;
            timeout_err_d = 1'b0;
`endif
        end
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            op_val_q    <= 1'b0;
            op_data_q   <= '0;
            res_ready_q <= 1'b0;
            out_val_q   <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            txn_cnt_q   <= 16'd0;
`ifdef CMH_TIMEOUT_EN
            wd_cnt_q      <= 16'd0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            op_val_q    <= op_val_d;
            op_data_q   <= op_data_d;
            res_ready_q <= res_ready_d;
            out_val_q   <= out_val_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            txn_cnt_q   <= txn_cnt_d;
`ifdef CMH_TIMEOUT_EN
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign in_full   = fifo_full;
    assign op_val    = op_val_q;
    assign op_data   = op_data_q;
    assign res_ready = res_ready_q;
    assign out_val   = out_val_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign busy      = (state_q != IDLE) || !fifo_empty;
    assign txn_cnt   = txn_cnt_q;
`ifdef CMH_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`endif

endmodule
